// File: rtl/mac_pkg.sv
// Shared types and sizing for the MAC dot-product sequencer.
// Sizing constants are kept here so the interface and the sequencer always agree.
package mac_pkg;

  localparam int DW      = 32;
  localparam int LENW    = 16;
  localparam int MAC_LAT = 1;
  localparam int ACC_W   = 2 * DW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Command, operand, MAC-side and result signals of the dot-product sequencer.
// The sequencer takes the slave view; the environment takes the master view.
interface mac_dot_sequencer_if;
  import mac_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [LENW-1:0]  cmd_len;

  logic             op_valid;
  logic             op_ready;
  logic [DW-1:0]    op_a;
  logic [DW-1:0]    op_b;

  logic             mac_reset;
  logic [DW-1:0]    mac_a;
  logic [DW-1:0]    mac_b;
  logic [ACC_W-1:0] mac_acc;

  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;

  modport slave (
    input  cmd_valid, cmd_len, op_valid, op_a, op_b, mac_acc, res_ready,
    output cmd_ready, op_ready, mac_reset, mac_a, mac_b, res_valid, res_data
  );

  modport master (
    output cmd_valid, cmd_len, op_valid, op_a, op_b, mac_acc, res_ready,
    input  cmd_ready, op_ready, mac_reset, mac_a, mac_b, res_valid, res_data
  );

endinterface

// File: rtl/mac_dot_sequencer.sv
// Sequences one dot-product command into the MAC: clear, stream N pairs, drain
// the MAC pipeline, then hold the captured accumulator until the consumer takes it.
//
// state  | meaning
// IDLE   | waiting for a command; length latched on accept
// CLEAR  | one cycle; schedules the single-cycle MAC clear
// STREAM | accepts operand pairs until the remaining count runs out
// DRAIN  | MAC_LAT+1 cycles of zero operands; accumulator captured on the last
// DONE   | result held valid until res_ready
module mac_dot_sequencer
  import mac_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  mac_dot_sequencer_if.slave  bus
);

  localparam int DRW = $clog2(MAC_LAT + 1) + 1;

  state_e           state_q;
  logic [LENW-1:0]  rem_q;
  logic [DRW-1:0]   drain_q;
  logic             mac_reset_q;
  logic [DW-1:0]    mac_a_q;
  logic [DW-1:0]    mac_b_q;
  logic             res_valid_q;
  logic [ACC_W-1:0] res_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      drain_q     <= '0;
      mac_reset_q <= 1'b1;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      // Idle operand cycles feed zeros so the accumulator holds its value.
      mac_reset_q <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            rem_q   <= bus.cmd_len;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          mac_reset_q <= 1'b1;
          drain_q     <= DRW'(MAC_LAT);
          state_q     <= (rem_q == '0) ? ST_DRAIN : ST_STREAM;
        end
        ST_STREAM: begin
          if (bus.op_valid) begin
            mac_a_q <= bus.op_a;
            mac_b_q <= bus.op_b;
            rem_q   <= rem_q - 1'b1;
            if (rem_q == LENW'(1)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            res_data_q  <= bus.mac_acc;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.op_ready  = (state_q == ST_STREAM);
  assign bus.mac_reset = mac_reset_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer paired with a behavioural 32-bit MAC.
// A timeline model predicts every output each cycle; directed tests pin literal results.
module tb_mac_dot_sequencer;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic reset;

  mac_dot_sequencer_if bus ();

  mac_dot_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: clear on mac_reset, otherwise accumulate A*B modulo 2^64.
  always @(posedge clk) begin
    if (bus.mac_reset) bus.mac_acc <= '0;
    else bus.mac_acc <= bus.mac_acc + 64'(bus.mac_a) * 64'(bus.mac_b);
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state: what the sequencer owes the world, in terms of cycle numbers.
  logic        m_busy = 1'b0;
  logic        m_after_reset = 1'b0;
  int          m_cmd_cyc, m_len, m_cnt, m_done_cyc;
  logic [63:0] m_sum;
  logic        prev_hs = 1'b0;
  logic [31:0] prev_a, prev_b;

  // Per-cycle samples used by the stimulus tasks.
  int          s_cyc;
  logic        s_cmd_hs, s_op_hs, s_res_valid, s_mac_reset, s_cmd_ready;
  logic [63:0] s_res_data;
  int          op_ready_cnt, res_valid_cnt, last_mac_reset_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic        ecr, eor, emr, erv;
    logic [31:0] ea, eb;
    cyc++;
    s_cyc       = cyc;
    s_cmd_hs    = bus.cmd_valid && bus.cmd_ready;
    s_op_hs     = bus.op_valid && bus.op_ready;
    s_res_valid = bus.res_valid;
    s_res_data  = bus.res_data;
    s_mac_reset = bus.mac_reset;
    s_cmd_ready = bus.cmd_ready;
    if (bus.op_ready) op_ready_cnt++;
    if (bus.res_valid) res_valid_cnt++;
    if (bus.mac_reset) last_mac_reset_cyc = cyc;
    if (reset) begin
      m_busy        = 1'b0;
      prev_hs       = 1'b0;
      m_after_reset = 1'b1;
    end else begin
      ecr = !m_busy;
      eor = m_busy && (cyc >= m_cmd_cyc + 2) && (m_cnt < m_len);
      emr = m_after_reset || (m_busy && cyc == m_cmd_cyc + 2);
      ea  = prev_hs ? prev_a : 32'd0;
      eb  = prev_hs ? prev_b : 32'd0;
      erv = m_busy && (m_cnt == m_len) && (cyc >= m_done_cyc);
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(ecr));
      chk("op_ready", 64'(bus.op_ready), 64'(eor));
      chk("mac_reset", 64'(bus.mac_reset), 64'(emr));
      chk("mac_a", 64'(bus.mac_a), 64'(ea));
      chk("mac_b", 64'(bus.mac_b), 64'(eb));
      chk("res_valid", 64'(bus.res_valid), 64'(erv));
      if (erv) chk("res_data", bus.res_data, m_sum);
      if (m_after_reset) chk("res_data_after_reset", bus.res_data, 64'd0);

      prev_hs = eor && bus.op_valid;
      prev_a  = bus.op_a;
      prev_b  = bus.op_b;
      if (prev_hs) begin
        m_sum = m_sum + 64'(bus.op_a) * 64'(bus.op_b);
        m_cnt++;
        if (m_cnt == m_len) m_done_cyc = cyc + MAC_LAT + 2;
      end
      if (erv && bus.res_ready) begin
        m_busy = 1'b0;
      end else if (ecr && bus.cmd_valid) begin
        m_busy     = 1'b1;
        m_cmd_cyc  = cyc;
        m_len      = int'(bus.cmd_len);
        m_cnt      = 0;
        m_sum      = 64'd0;
        m_done_cyc = (m_len == 0) ? cyc + MAC_LAT + 3 : (1 << 30);
      end
      m_after_reset = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int len, output int c0);
    logic ok = 1'b0;
    c0 = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LENW'(len);
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (s_cmd_hs) begin
        ok = 1'b1;
        c0 = s_cyc;
      end
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL cmd_timeout actual=no_handshake required=handshake");
    end
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input int gap,
                           output int hs_cyc);
    logic ok = 1'b0;
    hs_cyc = 0;
    bus.op_valid = 1'b0;
    repeat (gap) tick();
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (s_op_hs) begin
        ok = 1'b1;
        hs_cyc = s_cyc;
      end
    end
    bus.op_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL op_timeout actual=no_handshake required=handshake");
    end
  endtask

  task automatic wait_res(input int hold, output int rc, output logic [63:0] rd);
    logic ok = 1'b0;
    rc = 0;
    rd = '0;
    bus.res_ready = (hold == 0);
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (s_res_valid) begin
        ok = 1'b1;
        rc = s_cyc;
        rd = s_res_data;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL res_timeout actual=no_res_valid required=res_valid");
    end else if (hold > 0) begin
      repeat (hold - 1) tick();
      bus.res_ready = 1'b1;
      tick();
    end
    bus.res_ready = 1'b0;
  endtask

  initial begin
    int c0, hs, rc;
    logic [63:0] rd;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_mac_reset", 64'(s_mac_reset), 64'd1);
    chk("reset_cmd_ready", 64'(s_cmd_ready), 64'd1);
    chk("reset_res_valid", 64'(s_res_valid), 64'd0);
    chk("reset_res_data", s_res_data, 64'd0);

    // Full-rate N=4.
    send_cmd(4, c0);
    send_pair(32'd1, 32'd2, 0, hs);
    send_pair(32'd3, 32'd4, 0, hs);
    send_pair(32'd5, 32'd6, 0, hs);
    send_pair(32'd7, 32'd8, 0, hs);
    wait_res(0, rc, rd);
    chk("n4_data", rd, 64'd100);
    chk("n4_latency", 64'(rc - c0), 64'd8);

    // N=0 with operands offered throughout; they must be ignored.
    bus.op_valid = 1'b1;
    bus.op_a     = 32'd5;
    bus.op_b     = 32'd5;
    op_ready_cnt = 0;
    send_cmd(0, c0);
    wait_res(0, rc, rd);
    bus.op_valid = 1'b0;
    chk("n0_data", rd, 64'd0);
    chk("n0_latency", 64'(rc - c0), 64'd4);
    chk("n0_op_ready_cnt", 64'(op_ready_cnt), 64'd0);
    chk("n0_mac_reset_cyc", 64'(last_mac_reset_cyc - c0), 64'd2);

    // N=3 with two idle cycles before each pair.
    send_cmd(3, c0);
    send_pair(32'd10, 32'd20, 2, hs);
    send_pair(32'd30, 32'd40, 2, hs);
    send_pair(32'd50, 32'd60, 2, hs);
    wait_res(0, rc, rd);
    chk("gap_data", rd, 64'd4400);
    chk("gap_latency", 64'(rc - hs), 64'd3);

    // Modulo wrap of the accumulator.
    send_cmd(2, c0);
    send_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, hs);
    send_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, hs);
    wait_res(0, rc, rd);
    chk("wrap_data", rd, 64'hFFFF_FFFC_0000_0002);

    // Result back-pressure for 10 cycles with a follow-on command already offered.
    send_cmd(1, c0);
    send_pair(32'd7, 32'd6, 0, hs);
    res_valid_cnt = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = '0;
    wait_res(10, rc, rd);
    chk("hold_data", rd, 64'd42);
    chk("hold_valid_cycles", 64'(res_valid_cnt), 64'd11);
    tick();
    bus.cmd_valid = 1'b0;
    chk("reentry_cmd_hs", 64'(s_cmd_hs), 64'd1);
    wait_res(0, rc, rd);
    chk("reentry_n0_data", rd, 64'd0);

    // Reset mid-stream, then a clean N=1 run.
    send_cmd(5, c0);
    send_pair(32'd1, 32'd1, 0, hs);
    send_pair(32'd2, 32'd2, 0, hs);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("abort_mac_reset", 64'(s_mac_reset), 64'd1);
    chk("abort_res_valid", 64'(s_res_valid), 64'd0);
    chk("abort_cmd_ready", 64'(s_cmd_ready), 64'd1);
    send_cmd(1, c0);
    send_pair(32'd3, 32'd3, 0, hs);
    wait_res(0, rc, rd);
    chk("after_abort_data", rd, 64'd9);
    chk("after_abort_latency", 64'(rc - c0), 64'd5);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
